aes_decrypt_core: RTL and testbench



---
 rtl/aes_decrypt_core.sv | 236 +++++++++++++++++++++++
 tb/tb_aes_decrypt_core.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryption core: one AES step per clock, sequenced by a single FSM.
// Optional round-key cache that skips key expansion for a repeated key: AES_KEYCACHE_EN.
module aes_decrypt_core (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         AES_START,
  input  logic [127:0] AES_KEY,
  input  logic [127:0] AES_MSG_ENC,
  output logic [127:0] AES_MSG_DEC,
  output logic         AES_DONE,
  output logic         AES_BUSY
);

  typedef enum logic [3:0] {
    StIdle, StKeyExp, StInitArk, StRIsr, StRIsb, StRArk, StRImc,
    StFIsr, StFIsb, StFArk, StDone
  } state_e;

  state_e       r_fsm, w_fsm_next;
  logic [127:0] r_state, r_msg_dec;
  logic [127:0] r_rk [0:10];
  logic [3:0]   r_round;
  logic         r_done, r_busy;
  logic         w_key_hit;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int unsigned n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Circulant {0e,0b,0d,09} row, multiplies built from xtime chains
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      o[31-8*i -: 8] = (x8[i] ^ x4[i] ^ x2[i])
                     ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
                     ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                     ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
            inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0: return 8'h01;
      4'd1: return 8'h02;
      4'd2: return 8'h04;
      4'd3: return 8'h08;
      4'd4: return 8'h10;
      4'd5: return 8'h20;
      4'd6: return 8'h40;
      4'd7: return 8'h80;
      4'd8: return 8'h1b;
      4'd9: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

`ifdef AES_KEYCACHE_EN
  logic [127:0] r_last_key;
  logic         r_keys_valid;

  assign w_key_hit = r_keys_valid && (AES_KEY == r_last_key);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_keys_valid <= 1'b0;
      r_last_key   <= '0;
    end else if (r_fsm == StIdle && AES_START && !w_key_hit) begin
      r_keys_valid <= 1'b0;
    end else if (r_fsm == StKeyExp && r_round == 4'd9) begin
      r_keys_valid <= 1'b1;
      r_last_key   <= r_rk[0];
    end
  end
`else
  assign w_key_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) r_fsm <= StIdle;
    else       r_fsm <= w_fsm_next;
  end

  always_comb begin
    w_fsm_next = r_fsm;
    case (r_fsm)
      StIdle:    if (AES_START) w_fsm_next = w_key_hit ? StInitArk : StKeyExp;
      StKeyExp:  if (r_round == 4'd9) w_fsm_next = StInitArk;
      StInitArk: w_fsm_next = StRIsr;
      StRIsr:    w_fsm_next = StRIsb;
      StRIsb:    w_fsm_next = StRArk;
      StRArk:    w_fsm_next = StRImc;
      StRImc:    w_fsm_next = (r_round == 4'd1) ? StFIsr : StRIsr;
      StFIsr:    w_fsm_next = StFIsb;
      StFIsb:    w_fsm_next = StFArk;
      StFArk:    w_fsm_next = StDone;
      StDone:    if (r_done && !AES_START) w_fsm_next = StIdle;
      default:   w_fsm_next = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= '0;
      r_msg_dec <= '0;
      r_round   <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      for (int i = 0; i < 11; i++) r_rk[i] <= '0;
    end else begin
      case (r_fsm)
        StIdle: if (AES_START) begin
          r_rk[0] <= AES_KEY;
          r_state <= AES_MSG_ENC;
          r_round <= '0;
          r_busy  <= 1'b1;
        end
        StKeyExp: begin
          r_rk[r_round + 4'd1] <= key_expand(r_rk[r_round], rcon(r_round));
          r_round              <= r_round + 4'd1;
        end
        StInitArk: begin
          r_state <= r_state ^ r_rk[10];
          r_round <= 4'd9;
        end
        StRIsr, StFIsr: r_state <= inv_shift_rows(r_state);
        StRIsb, StFIsb: r_state <= inv_sub_bytes(r_state);
        StRArk:         r_state <= r_state ^ r_rk[r_round];
        StRImc: begin
          r_state <= inv_mix_columns(r_state);
          r_round <= r_round - 4'd1;
        end
        StFArk:         r_state <= r_state ^ r_rk[0];
        // First DONE cycle publishes the result; later cycles wait for START to drop
        StDone: begin
          if (!r_done) begin
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_msg_dec <= r_state;
          end else if (!AES_START) begin
            r_done <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign AES_MSG_DEC = r_msg_dec;
  assign AES_DONE    = r_done;
  assign AES_BUSY    = r_busy;

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Self-checking bench for aes_decrypt_core: FIPS-197 vectors plus random plaintexts encrypted
// by a forward AES model; latency expectations follow AES_KEYCACHE_EN when it is defined.
module tb_aes_decrypt_core;

  logic         CLK, RESET, AES_START;
  logic [127:0] AES_KEY, AES_MSG_ENC, AES_MSG_DEC;
  logic         AES_DONE, AES_BUSY;

  int total = 0;
  int bad   = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] last_dec;
  logic [127:0] cache_key;
  bit           cache_valid;

  localparam int LatBound = 80;
`ifdef AES_KEYCACHE_EN
  localparam bit CacheEn = 1'b1;
`else
  localparam bit CacheEn = 1'b0;
`endif

  typedef struct {
    string        nm;
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t vecs [2];

  aes_decrypt_core u_dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .AES_START   (AES_START),
    .AES_KEY     (AES_KEY),
    .AES_MSG_ENC (AES_MSG_ENC),
    .AES_MSG_DEC (AES_MSG_DEC),
    .AES_DONE    (AES_DONE),
    .AES_BUSY    (AES_BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box from walking generator 3 and its inverse (generator 0xf6) together
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ ((p & 8'h80) != 0 ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      q = q ^ ((q & 8'h80) != 0 ? 8'h09 : 8'h00);
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] w [176];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] rc, t0, t1, t2, t3, tmp;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) w[i] = key[127-8*i -: 8];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t0 = w[4*i-4]; t1 = w[4*i-3]; t2 = w[4*i-2]; t3 = w[4*i-1];
      if (i % 4 == 0) begin
        tmp = t0;
        t0 = sbox_t[t1] ^ rc; t1 = sbox_t[t2]; t2 = sbox_t[t3]; t3 = sbox_t[tmp];
        rc = xt(rc);
      end
      w[4*i]   = w[4*i-16] ^ t0;
      w[4*i+1] = w[4*i-15] ^ t1;
      w[4*i+2] = w[4*i-14] ^ t2;
      w[4*i+3] = w[4*i-13] ^ t3;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++) begin
        if (rnd < 10) begin
          s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
          s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rnd+i];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic int exp_lat(input logic [127:0] key);
    return (CacheEn && cache_valid && key == cache_key) ? 41 : 51;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    AES_START = 1'b0;
    repeat (2) begin @(posedge CLK); #1; end
    RESET = 1'b0;
    cache_valid = 1'b0;
    last_dec = '0;
  endtask

  task automatic run_op(input string nm, input logic [127:0] key, input logic [127:0] ct,
                        input logic [127:0] pt, input int corrupt_at);
    int lat, want;
    bit busy_ok, hold_ok;
    want = exp_lat(key);
    AES_KEY = key;
    AES_MSG_ENC = ct;
    AES_START = 1'b1;
    @(posedge CLK); #1;
    lat = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    for (int n = 1; n <= LatBound; n++) begin
      @(posedge CLK); #1;
      if (n == corrupt_at) begin
        AES_KEY = '0;
        AES_MSG_ENC = '0;
      end
      if (AES_DONE === 1'b1) begin
        lat = n;
        break;
      end
      if (AES_BUSY !== 1'b1) busy_ok = 1'b0;
      if (AES_MSG_DEC !== last_dec) hold_ok = 1'b0;
    end
    chk({nm, " latency"}, 128'(lat), 128'(want));
    chk({nm, " busy while running"}, 128'(busy_ok), 128'd1);
    chk({nm, " result held while running"}, 128'(hold_ok), 128'd1);
    chk({nm, " busy after done"}, 128'(AES_BUSY), 128'd0);
    chk({nm, " plaintext"}, AES_MSG_DEC, pt);
    last_dec = pt;
    cache_valid = 1'b1;
    cache_key = key;
  endtask

  task automatic stop_op(input string nm);
    AES_START = 1'b0;
    @(posedge CLK); #1;
    chk({nm, " done falls"}, 128'(AES_DONE), 128'd0);
    chk({nm, " result retained"}, AES_MSG_DEC, last_dec);
  endtask

  initial begin
    logic [127:0] k, p;
    bit hold_done, hold_idle;
    build_sbox();
    vecs[0] = '{nm: "fips_b", key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                ct: 128'h3925841d02dc09fbdc118597196a0b32,
                pt: 128'h3243f6a8885a308d313198a2e0370734};
    vecs[1] = '{nm: "fips_c1", key: 128'h000102030405060708090a0b0c0d0e0f,
                ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                pt: 128'h00112233445566778899aabbccddeeff};
    AES_KEY = '0;
    AES_MSG_ENC = '0;
    AES_START = 1'b0;
    RESET = 1'b0;
    cache_key = '0;
    do_reset();
    chk("reset msg_dec", AES_MSG_DEC, 128'd0);
    chk("reset done", 128'(AES_DONE), 128'd0);
    chk("reset busy", 128'(AES_BUSY), 128'd0);

    for (int i = 0; i < 2; i++) begin
      run_op(vecs[i].nm, vecs[i].key, vecs[i].ct, vecs[i].pt, 0);
      stop_op(vecs[i].nm);
    end

    // Inputs zeroed mid-operation must not disturb the latched operands
    run_op("corrupt", vecs[0].key, vecs[0].ct, vecs[0].pt, 20);
    stop_op("corrupt");

    // Reset at cycle 30 of an operation
    AES_KEY = vecs[1].key;
    AES_MSG_ENC = vecs[1].ct;
    AES_START = 1'b1;
    @(posedge CLK); #1;
    repeat (30) begin @(posedge CLK); #1; end
    RESET = 1'b1;
    AES_START = 1'b0;
    @(posedge CLK); #1;
    chk("midreset busy", 128'(AES_BUSY), 128'd0);
    chk("midreset done", 128'(AES_DONE), 128'd0);
    chk("midreset msg_dec", AES_MSG_DEC, 128'd0);
    RESET = 1'b0;
    cache_valid = 1'b0;
    last_dec = '0;
    run_op("after_reset", vecs[1].key, vecs[1].ct, vecs[1].pt, 0);
    stop_op("after_reset");

    // START held through DONE: no restart until START drops and rises again
    run_op("hold", vecs[1].key, vecs[1].ct, vecs[1].pt, 0);
    hold_done = 1'b1;
    repeat (5) begin
      @(posedge CLK); #1;
      if (AES_DONE !== 1'b1 || AES_BUSY !== 1'b0) hold_done = 1'b0;
    end
    chk("hold done stays high", 128'(hold_done), 128'd1);
    stop_op("hold");
    hold_idle = 1'b1;
    repeat (3) begin
      @(posedge CLK); #1;
      if (AES_BUSY !== 1'b0 || AES_DONE !== 1'b0) hold_idle = 1'b0;
    end
    chk("no restart with start low", 128'(hold_idle), 128'd1);
    run_op("restart", vecs[1].key, vecs[1].ct, vecs[1].pt, 0);
    stop_op("restart");
    run_op("key_switch", vecs[0].key, vecs[0].ct, vecs[0].pt, 0);
    stop_op("key_switch");

    // Random plaintexts; odd iterations reuse the previous key
    k = '0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) k = {$urandom(), $urandom(), $urandom(), $urandom()};
      p = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_op($sformatf("rand%0d", i), k, aes_enc(k, p), p, 0);
      stop_op($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
